pg_precompute_stage: RTL

PG_PRECOMPUTE_STAGE -- requirements
Module: pg_precompute_stage

---
 rtl/pg_precompute_stage_pkg.sv | 18 +
 rtl/pg_precompute_stage_pg_cell.sv | 17 +
 rtl/pg_precompute_stage.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/pg_precompute_stage_pkg.sv
// pg_precompute_stage_pkg
// Shared definitions for the adder pipeline stages (PG precompute, prefix
// network, sum). Holds the two-entry buffer state enumeration and the default
// operand and transaction-counter widths so every stage agrees on them.
package pg_precompute_stage_pkg;

  localparam int PG_WIDTH_DEFAULT = 16;
  localparam int PG_CNT_W_DEFAULT = 16;

  // Occupancy of a two-entry output buffer: nothing held, output register
  // only, or output register plus skid register.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } buf_state_t;

endpackage

// File: rtl/pg_precompute_stage_pg_cell.sv
// pg_cell
// Single-bit generate/propagate cell used by the PG precompute stage.
// Ports:
//   a, b : operand bits
//   g    : generate, a & b
//   p    : propagate, a ^ b
module pg_cell (
  input  logic a,
  input  logic b,
  output logic g,
  output logic p
);

  assign g = a & b;
  assign p = a ^ b;

endmodule

// File: rtl/pg_precompute_stage.sv
// pg_precompute_stage
// First stage of a parallel-prefix adder. Computes the bitwise generate and
// propagate vectors of a + b + cin (carry-in folded into generate bit 0) and
// hands them downstream through a two-entry valid/ready buffer: an output
// register plus a skid register, so in_ready can be fully registered while
// still sustaining one set per cycle.
// Ports:
//   clk, rst             : clock, asynchronous active-high reset
//   in_valid, in_ready   : upstream handshake for operands a, b, cin
//   a, b, cin            : operands and carry-in
//   out_valid, out_ready : downstream handshake for g_out, p_out
//   g_out, p_out         : generate vector (cin folded) and raw propagate
//   txn_count            : number of PG vectors delivered, wraps
module pg_precompute_stage
  import pg_precompute_stage_pkg::*;
#(
  parameter int WIDTH = PG_WIDTH_DEFAULT,
  parameter int CNT_W = PG_CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] g_out,
  output logic [WIDTH-1:0] p_out,
  output logic [CNT_W-1:0] txn_count
);

  logic [WIDTH-1:0] g_bit;
  logic [WIDTH-1:0] p_bit;
  logic [WIDTH-1:0] g_in;
  logic [WIDTH-1:0] skid_g;
  logic [WIDTH-1:0] skid_p;
  buf_state_t       state;
  buf_state_t       state_next;
  logic             accept;
  logic             drain;
  logic             load_out_in;
  logic             load_out_skid;
  logic             load_skid;

  // One PG cell per operand bit.
  for (genvar i = 0; i < WIDTH; i++) begin : g_cells
    pg_cell u_cell (
      .a(a[i]),
      .b(b[i]),
      .g(g_bit[i]),
      .p(p_bit[i])
    );
  end

  // Bit 0 generate absorbs the carry-in, so the prefix network never has to
  // treat cin specially. Propagate stays raw because the sum stage needs a^b.
  assign g_in = {g_bit[WIDTH-1:1], g_bit[0] | (p_bit[0] & cin)};

  assign out_valid = (state != EMPTY);
  assign accept    = in_valid & in_ready;
  assign drain     = out_valid & out_ready;

  // Buffer control. A new set goes to the output register whenever that
  // register is free or being drained this cycle; it only lands in the skid
  // register when the output register is held by backpressure. Leaving FULL
  // always moves the skid entry forward, which keeps ordering FIFO.
  always_comb begin
    state_next    = state;
    load_out_in   = 1'b0;
    load_out_skid = 1'b0;
    load_skid     = 1'b0;
    case (state)
      EMPTY: begin
        if (accept) begin
          state_next  = ONE;
          load_out_in = 1'b1;
        end
      end
      ONE: begin
        if (accept && drain) begin
          load_out_in = 1'b1;
        end else if (accept) begin
          state_next = FULL;
          load_skid  = 1'b1;
        end else if (drain) begin
          state_next = EMPTY;
        end
      end
      FULL: begin
        if (drain) begin
          state_next    = ONE;
          load_out_skid = 1'b1;
        end
      end
      default: begin
        state_next = EMPTY;
      end
    endcase
  end

  // State register. in_ready is registered from the next state so that
  // out_ready never reaches in_ready combinationally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= EMPTY;
      in_ready <= 1'b1;
    end else begin
      state    <= state_next;
      in_ready <= (state_next != FULL);
    end
  end

  // Data registers for the output and skid entries.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      g_out  <= '0;
      p_out  <= '0;
      skid_g <= '0;
      skid_p <= '0;
    end else begin
      if (load_out_in) begin
        g_out <= g_in;
        p_out <= p_bit;
      end else if (load_out_skid) begin
        g_out <= skid_g;
        p_out <= skid_p;
      end
      if (load_skid) begin
        skid_g <= g_in;
        skid_p <= p_bit;
      end
    end
  end

  // Delivered-vector counter, wraps naturally at 2^CNT_W.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      txn_count <= '0;
    end else if (drain) begin
      txn_count <= txn_count + CNT_W'(1);
    end
  end

endmodule
